prism_exec_core: RTL and testbench
==================================

// Module: prism_exec_core
// PURPOSE
//  Execution stage of PRISM. Owns the current-state register, drives the SIT read
//  address, and decodes the returned SI word into a condition, a next state, registered
//  outputs and a dwell counter. Sits directly downstream of prism_latch_sit (raddr1/rdata1).
// PARAMETERS
//  WIDTH   80  SI word width; must be >= 48
//  DEPTH   2   number of states / SIT entries
//  A_BITS  1   state/address width (1 for DEPTH<=2 ... 6 for DEPTH<=64)
//  N_IN    8   number of condition inputs (selects are 3 bits, so N_IN<=8)
//  N_OUT   8   number of PRISM outputs (<=8)
//  SYNC_IN 1   1 = 2-flop synchronizer on in_sig; 0 = direct
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       synchronous reset, active low
//  en         in   1       run enable; 0 freezes all state
//  restart    in   1       1-cycle pulse: soft return to state 0
//  in_sig     in   N_IN    condition inputs
//  raddr1     out  A_BITS  SIT read address (= cur_state, combinational from register)
//  rdata1     in   WIDTH   SI word for raddr1, valid same cycle
//  out_sig    out  N_OUT   registered PRISM outputs
//  cur_state  out  A_BITS  current state
//  cnt        out  8       dwell counter
//  err        out  1       sticky: next-state target >= DEPTH was taken
// BEHAVIOUR
//  SI fields: [2:0] sel0, [3] inv0, [6:4] sel1, [7] inv1, [9:8] op,
//   [15:10] nxt (low A_BITS used), [23:16] out_true, [31:24] out_false,
//   [32] cnt_load, [33] cnt_dec, [34] use_cnt, [39:35] rsvd, [47:40] reload,
//   [WIDTH-1:48] ignored. sel >= N_IN reads 0.
//  c0 = s[sel0]^inv0, c1 = s[sel1]^inv1, with s = synced in_sig (2-cycle latency
//   when SYNC_IN=1). op: 00 c0, 01 c0&c1, 10 c0|c1, 11 c0^c1.
//  cond = op_result & (use_cnt ? (cnt==0) : 1).
//  Reset (rst_n=0 at edge): cur_state=0, out_sig=0, cnt=0, err=0, sync flops=0.
//  Priority per edge: rst_n low > restart > en > hold.
//  restart=1: cur_state=0, cnt=0, out_sig=0; err kept; independent of en.
//  en=1, cond=1: cur_state<=nxt; out_sig<=out_true[N_OUT-1:0];
//   cnt<=reload if cnt_load else unchanged. If nxt>=DEPTH: cur_state<=0, err<=1.
//  en=1, cond=0: cur_state holds; out_sig<=out_false[N_OUT-1:0];
//   if cnt_dec and cnt!=0, cnt<=cnt-1 (saturates at 0, no wrap).
//  cnt_load and cnt_dec never act together (exclusive by cond).
//  en=0: cur_state, out_sig, cnt, err hold; sync flops keep sampling.
//  Latency: one evaluation per enabled clock; out_sig/cur_state change 1 cycle after
//   the evaluated edge. Self-loop (nxt==cur_state) still reloads cnt if cnt_load.
//  rdata1 changing mid-run (SIT reprogram) takes effect on the next evaluation.
// TESTING
//  1 Reset: hold rst_n=0 2 clks with en=1 -> state=0, out_sig=0, cnt=0, err=0.
//  2 SYNC_IN=1, S0: sel0=2, op=00, nxt=1, out_true=A5, out_false=3C; in_sig[2]
//    0->1 -> out_sig=3C until 3rd edge after change, then state=1, out_sig=A5.
//  3 Dwell: S0 cnt_load, reload=5, nxt=1; S1 use_cnt, cnt_dec, input true, nxt=0
//    -> cnt 5,4,3,2,1,0 in S1 then return to S0 on the edge after cnt==0.
//  4 en=0 for 4 clks mid-count at cnt=3 -> all outputs frozen; resume at 3.
//  5 DEPTH=3, nxt=3 taken -> cur_state=0, err=1; restart pulse -> err stays 1.
//  6 restart and cond=1 same edge -> state=0, cnt=0, out_sig=0 (restart wins);
//    op=11 with inv1=1, in_sig[sel0]=in_sig[sel1]=1 -> cond=1.

Source files
------------

// File: rtl/prism_exec_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prism_exec_core : PRISM execution stage (SIT decode, state, outputs, dwell)
// rev 1.0
// ---------------------------------------------------------------------------
module prism_exec_core #(
  parameter int WIDTH   = 80,
  parameter int DEPTH   = 2,
  parameter int A_BITS  = 1,
  parameter int N_IN    = 8,
  parameter int N_OUT   = 8,
  parameter int SYNC_IN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              restart,
  input  logic [N_IN-1:0]   in_sig,
  output logic [A_BITS-1:0] raddr1,
  input  logic [WIDTH-1:0]  rdata1,
  output logic [N_OUT-1:0]  out_sig,
  output logic [A_BITS-1:0] cur_state,
  output logic [7:0]        cnt,
  output logic              err
);

  logic [N_IN-1:0]   s;
  logic [7:0]        s_pad;
  logic [2:0]        sel0, sel1;
  logic              inv0, inv1, c0, c1, op_res, cond;
  logic [1:0]        op;
  logic [A_BITS-1:0] nxt;
  logic              nxt_bad;
  logic [N_OUT-1:0]  out_true, out_false;
  logic              cnt_load, cnt_dec, use_cnt;
  logic [7:0]        reload;
  logic              unused_bits;

  generate
    if (SYNC_IN != 0) begin : g_sync
      logic [N_IN-1:0] sync1, sync2;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync1 <= '0;
          sync2 <= '0;
        end else begin
          sync1 <= in_sig;
          sync2 <= sync1;
        end
      end
      assign s = sync2;
    end else begin : g_direct
      assign s = in_sig;
    end
  endgenerate

  // Selects can address up to 8 inputs; absent inputs read as 0.
  assign s_pad     = 8'(s);
  assign sel0      = rdata1[2:0];
  assign inv0      = rdata1[3];
  assign sel1      = rdata1[6:4];
  assign inv1      = rdata1[7];
  assign op        = rdata1[9:8];
  assign nxt       = rdata1[10 +: A_BITS];
  assign out_true  = rdata1[16 +: N_OUT];
  assign out_false = rdata1[24 +: N_OUT];
  assign cnt_load  = rdata1[32];
  assign cnt_dec   = rdata1[33];
  assign use_cnt   = rdata1[34];
  assign reload    = rdata1[47:40];
  // Reserved and ignored SI bits are intentionally left undecoded.
  assign unused_bits = ^rdata1;

  assign c0      = s_pad[sel0] ^ inv0;
  assign c1      = s_pad[sel1] ^ inv1;
  assign nxt_bad = ({{(32-A_BITS){1'b0}}, nxt} >= 32'(DEPTH));

  always_comb begin
    op_res = c0;
    case (op)
      2'b00: op_res = c0;
      2'b01: op_res = c0 & c1;
      2'b10: op_res = c0 | c1;
      2'b11: op_res = c0 ^ c1;
      default: op_res = c0;
    endcase
    cond = op_res & (~use_cnt | (cnt == 8'd0));
  end

  assign raddr1 = cur_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= '0;
      out_sig   <= '0;
      cnt       <= '0;
      err       <= 1'b0;
    end else if (restart) begin
      cur_state <= '0;
      out_sig   <= '0;
      cnt       <= '0;
    end else if (en) begin
      if (cond) begin
        cur_state <= nxt_bad ? '0 : nxt;
        err       <= err | nxt_bad;
        out_sig   <= out_true;
        if (cnt_load) cnt <= reload;
      end else begin
        out_sig <= out_false;
        if (cnt_dec && (cnt != 8'd0)) cnt <= cnt - 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prism_exec_core.sv
`default_nettype none
// Bench for prism_exec_core: directed scenarios plus random traffic, all
// cycles compared against a behavioural model that plays the SIT role.
module tb_prism_exec_core;
  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n, en, restart;
  logic [7:0]  in_sig;
  logic [1:0]  raddr1, cur_state;
  logic [79:0] rdata1;
  logic [7:0]  out_sig, cnt;
  logic        err;
  logic [79:0] sit [0:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rdata1 = sit[raddr1];

  prism_exec_core #(
    .WIDTH(80), .DEPTH(DEPTH), .A_BITS(2), .N_IN(8), .N_OUT(8), .SYNC_IN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .in_sig(in_sig),
    .raddr1(raddr1), .rdata1(rdata1), .out_sig(out_sig),
    .cur_state(cur_state), .cnt(cnt), .err(err)
  );

  typedef struct packed {
    logic [1:0] state;
    logic [7:0] out;
    logic [7:0] cnt;
    logic       err;
    logic [7:0] h0;   // in_sig seen at the previous edge
    logic [7:0] h1;   // in_sig seen two edges ago
  } model_t;

  model_t m = '0;

  function automatic model_t step(model_t cur, logic rn, logic rs, logic e,
                                  logic [7:0] in, logic [79:0] w);
    model_t n = cur;
    int sel0 = int'(w[2:0]);
    int sel1 = int'(w[6:4]);
    int nxt  = int'(w[15:10]) % 4;
    bit c0 = cur.h1[sel0] ^ w[3];
    bit c1 = cur.h1[sel1] ^ w[7];
    bit r;
    bit cond;
    case (w[9:8])
      2'd0: r = c0;
      2'd1: r = c0 && c1;
      2'd2: r = c0 || c1;
      default: r = (c0 != c1);
    endcase
    cond = r && (!w[34] || cur.cnt == 0);
    n.h1 = cur.h0;
    n.h0 = in;
    if (!rn) begin
      n = '0;
    end else if (rs) begin
      n.state = 0; n.cnt = 0; n.out = 0;
    end else if (e) begin
      if (cond) begin
        if (nxt >= DEPTH) begin n.state = 0; n.err = 1'b1; end
        else n.state = 2'(nxt);
        n.out = w[23:16];
        if (w[32]) n.cnt = w[47:40];
      end else begin
        n.out = w[31:24];
        if (w[33] && cur.cnt > 0) n.cnt = cur.cnt - 8'd1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst_n, restart, en, in_sig, sit[m.state]);

  function automatic logic [79:0] mk(int sel0, int inv0, int sel1, int inv1,
                                     int op, int nxt, int ot, int of,
                                     int ld, int dc, int uc, int rl);
    return {32'h0, 8'(rl), 5'b0, 1'(uc), 1'(dc), 1'(ld), 8'(of), 8'(ot),
            6'(nxt), 2'(op), 1'(inv1), 3'(sel1), 1'(inv0), 3'(sel0)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic cyc();
    @(negedge clk);
    check_eq("state",  32'(cur_state), 32'(m.state));
    check_eq("raddr",  32'(raddr1),    32'(m.state));
    check_eq("out",    32'(out_sig),   32'(m.out));
    check_eq("cnt",    32'(cnt),       32'(m.cnt));
    check_eq("err",    32'(err),       32'(m.err));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; restart = 1'b0; in_sig = 8'h00;
    for (int i = 0; i < 4; i++) sit[i] = '0;

    // Reset with en held high
    cyc(); cyc();
    check_eq("rst_state", 32'(cur_state), 32'h0);
    check_eq("rst_out",   32'(out_sig),   32'h0);
    check_eq("rst_cnt",   32'(cnt),       32'h0);
    check_eq("rst_err",   32'(err),       32'h0);

    // Synchronizer latency on a simple transition
    sit[0] = mk(2, 0, 0, 0, 0, 1, 'hA5, 'h3C, 0, 0, 0, 0);
    sit[1] = mk(0, 0, 0, 0, 0, 1, 'h55, 'h11, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc();
    check_eq("t2_pre", 32'(out_sig), 32'h3C);
    in_sig = 8'h04;
    cyc(); cyc();
    check_eq("t2_e2_out",   32'(out_sig),   32'h3C);
    check_eq("t2_e2_state", 32'(cur_state), 32'h0);
    cyc();
    check_eq("t2_e3_out",   32'(out_sig),   32'hA5);
    check_eq("t2_e3_state", 32'(cur_state), 32'h1);

    // Dwell counter with a freeze in the middle
    sit[0] = mk(2, 0, 0, 0, 0, 1, 'h01, 'h02, 1, 0, 0, 5);
    sit[1] = mk(2, 0, 0, 0, 0, 0, 'h44, 'h22, 0, 1, 1, 0);
    restart = 1'b1;
    cyc();
    check_eq("rs_state", 32'(cur_state), 32'h0);
    check_eq("rs_cnt",   32'(cnt),       32'h0);
    restart = 1'b0;
    cyc();
    check_eq("dw_load", 32'(cnt), 32'd5);
    cyc(); check_eq("dw_4", 32'(cnt), 32'd4);
    cyc(); check_eq("dw_3", 32'(cnt), 32'd3);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("frz_cnt",   32'(cnt),       32'd3);
      check_eq("frz_out",   32'(out_sig),   32'h22);
      check_eq("frz_state", 32'(cur_state), 32'h1);
    end
    en = 1'b1;
    cyc(); check_eq("dw_2", 32'(cnt), 32'd2);
    cyc(); check_eq("dw_1", 32'(cnt), 32'd1);
    cyc(); check_eq("dw_0", 32'(cnt), 32'd0);
    check_eq("dw_hold", 32'(cur_state), 32'h1);
    cyc();
    check_eq("dw_ret", 32'(cur_state), 32'h0);
    check_eq("dw_out", 32'(out_sig),   32'h44);
    check_eq("pre_err", 32'(err), 32'h0);

    // Out-of-range next state sets sticky err
    sit[0] = mk(2, 0, 0, 0, 0, 3, 'h66, 'h00, 0, 0, 0, 0);
    cyc();
    check_eq("oob_state", 32'(cur_state), 32'h0);
    check_eq("oob_err",   32'(err),       32'h1);
    restart = 1'b1;
    cyc();
    check_eq("oob_sticky", 32'(err), 32'h1);

    // Restart beats a true condition; op=11 with inv1
    sit[0] = mk(2, 0, 2, 1, 3, 1, 'h77, 'h00, 1, 0, 0, 9);
    cyc();
    check_eq("rw_state", 32'(cur_state), 32'h0);
    check_eq("rw_cnt",   32'(cnt),       32'h0);
    check_eq("rw_out",   32'(out_sig),   32'h0);
    restart = 1'b0;
    cyc();
    check_eq("xor_state", 32'(cur_state), 32'h1);
    check_eq("xor_out",   32'(out_sig),   32'h77);
    check_eq("xor_cnt",   32'(cnt),       32'd9);

    // Random traffic including live SIT reprogramming
    for (int i = 0; i < 4; i++) sit[i] = {$urandom, $urandom, $urandom} >> 16;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(7) == 0)
        sit[$urandom_range(3)] = 80'({$urandom, $urandom, $urandom});
      in_sig  = 8'($urandom);
      en      = ($urandom_range(7) != 0);
      restart = ($urandom_range(15) == 0);
      rst_n   = ($urandom_range(63) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
